// File: rtl/accel_poll_scheduler.sv
// Accelerometer poll scheduler: configures the sensor over a byte-level SPI engine,
// then periodically bursts the X/Y sample registers and derives tilt direction.
module accel_poll_scheduler #(
   parameter int POLL_DIV = 500000,
   parameter int TIMEOUT  = 4096,
   parameter int TILT_TH  = 64
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iHOLD,
   output logic        oSPI_REQ,
   output logic        oSPI_WR,
   output logic [5:0]  oSPI_ADDR,
   output logic [7:0]  oSPI_WDATA,
   input  logic        iSPI_ACK,
   input  logic [7:0]  iSPI_RDATA,
   output logic [15:0] oX,
   output logic [15:0] oY,
   output logic        oVALID,
   output logic [1:0]  oDIR_X,
   output logic [1:0]  oDIR_Y,
   output logic        oSTOP,
   output logic        oINIT_DONE,
   output logic        oERR
);

   typedef enum logic [1:0] {S_CFG, S_WAIT, S_READ, S_UPDATE} state_t;

   localparam int DW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(POLL_DIV - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic signed [16:0] TH_POS = 17'(TILT_TH);
   localparam logic signed [16:0] TH_NEG = -TH_POS;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic          armed_q, armed_d;
   logic          req_q, req_d;
   logic          wr_q, wr_d;
   logic [5:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [DW-1:0] div_q, div_d;
   logic [7:0]    x0_q, x0_d, x1_q, x1_d, y0_q, y0_d;
   logic [15:0]   x_q, x_d, y_q, y_d;
   logic          valid_q, valid_d;
   logic [1:0]    dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic          init_done_q, init_done_d;
   logic          err_q, err_d;

   logic          ack_ok, tmo_hit;
   logic [15:0]   x_new, y_new;

   // An ack only counts while a request is outstanding; an ack in the final cycle wins.
   assign ack_ok  = req_q & iSPI_ACK;
   assign tmo_hit = req_q & ~iSPI_ACK & (tmo_q == TMO_LAST);
   assign x_new   = {x1_q, x0_q};
   assign y_new   = {iSPI_RDATA, y0_q};

   function automatic logic [1:0] dir_of(input logic [15:0] v);
      logic signed [16:0] s;
      s = {v[15], v};
      if (s > TH_POS)      dir_of = 2'b01;
      else if (s < TH_NEG) dir_of = 2'b10;
      else                 dir_of = 2'b00;
   endfunction

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= S_CFG;
         idx_q       <= 2'd0;
         armed_q     <= 1'b0;
         req_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= 6'd0;
         wdata_q     <= 8'd0;
         tmo_q       <= '0;
         div_q       <= '0;
         x0_q        <= 8'd0;
         x1_q        <= 8'd0;
         y0_q        <= 8'd0;
         x_q         <= 16'd0;
         y_q         <= 16'd0;
         valid_q     <= 1'b0;
         dir_x_q     <= 2'b00;
         dir_y_q     <= 2'b00;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         armed_q     <= armed_d;
         req_q       <= req_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tmo_q       <= tmo_d;
         div_q       <= div_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         y0_q        <= y0_d;
         x_q         <= x_d;
         y_q         <= y_d;
         valid_q     <= valid_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         init_done_q <= init_done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_CFG:   if (ack_ok && idx_q == 2'd2) state_d = S_WAIT;
         S_WAIT:  if (div_q == DIV_LAST && !iHOLD) state_d = S_READ;
         S_READ: begin
            if (tmo_hit)                       state_d = S_CFG;
            else if (ack_ok && idx_q == 2'd3)  state_d = S_UPDATE;
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_comb begin
      idx_d       = idx_q;
      armed_d     = 1'b1;
      req_d       = req_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      tmo_d       = (req_q && !iSPI_ACK && !tmo_hit) ? tmo_q + TW'(1) : '0;
      div_d       = div_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      y0_d        = y0_q;
      x_d         = x_q;
      y_d         = y_q;
      valid_d     = 1'b0;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      init_done_d = init_done_q;
      err_d       = err_q;
      unique case (state_q)
         S_CFG, S_READ: begin
            if (ack_ok) begin
               req_d = 1'b0;
               idx_d = idx_q + 2'd1;
               if (state_q == S_CFG) begin
                  if (idx_q == 2'd2) begin
                     idx_d       = 2'd0;
                     init_done_d = 1'b1;
                     div_d       = '0;
                  end
               end else begin
                  unique case (idx_q)
                     2'd0: x0_d = iSPI_RDATA;
                     2'd1: x1_d = iSPI_RDATA;
                     2'd2: y0_d = iSPI_RDATA;
                     default: begin
                        x_d     = x_new;
                        y_d     = y_new;
                        dir_x_d = dir_of(x_new);
                        dir_y_d = dir_of(y_new);
                        valid_d = 1'b1;
                     end
                  endcase
               end
            end else if (tmo_hit) begin
               req_d       = 1'b0;
               err_d       = 1'b1;
               init_done_d = 1'b0;
               idx_d       = 2'd0;
            end else if (!req_q && armed_q) begin
               // req_q low here guarantees a low cycle between transactions.
               req_d = 1'b1;
               if (state_q == S_CFG) begin
                  wr_d = 1'b1;
                  unique case (idx_q)
                     2'd0:    begin addr_d = 6'h31; wdata_d = 8'h08; end
                     2'd1:    begin addr_d = 6'h2C; wdata_d = 8'h0A; end
                     default: begin addr_d = 6'h2D; wdata_d = 8'h08; end
                  endcase
               end else begin
                  wr_d    = 1'b0;
                  addr_d  = 6'h32 + {4'd0, idx_q};
                  wdata_d = 8'h00;
               end
            end
         end
         S_WAIT: begin
            if (div_q != DIV_LAST) div_d = div_q + DW'(1);
            if (div_q == DIV_LAST && !iHOLD) idx_d = 2'd0;
         end
         default: div_d = '0;
      endcase
   end

   assign oSPI_REQ   = req_q;
   assign oSPI_WR    = wr_q;
   assign oSPI_ADDR  = addr_q;
   assign oSPI_WDATA = wdata_q;
   assign oX         = x_q;
   assign oY         = y_q;
   assign oVALID     = valid_q;
   assign oDIR_X     = dir_x_q;
   assign oDIR_Y     = dir_y_q;
   assign oSTOP      = (dir_x_q == 2'b00) && (dir_y_q == 2'b00);
   assign oINIT_DONE = init_done_q;
   assign oERR       = err_q;

endmodule

// File: tb/tb_accel_poll_scheduler.sv
// Directed bench for accel_poll_scheduler: an SPI responder acks each request after a
// programmable delay; checks config order, sample assembly, tilt, timeout, hold and reset.
module tb_accel_poll_scheduler;
   localparam int POLL_DIV = 20;
   localparam int TIMEOUT  = 16;
   localparam int TILT_TH  = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hold = 1'b0;
   logic        ack = 1'b0;
   logic [7:0]  rdata = 8'h00;
   logic        oSPI_REQ, oSPI_WR, oVALID, oSTOP, oINIT_DONE, oERR;
   logic [5:0]  oSPI_ADDR;
   logic [7:0]  oSPI_WDATA;
   logic [15:0] oX, oY;
   logic [1:0]  oDIR_X, oDIR_Y;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   accel_poll_scheduler #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .TILT_TH(TILT_TH)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iHOLD(hold),
      .oSPI_REQ(oSPI_REQ), .oSPI_WR(oSPI_WR), .oSPI_ADDR(oSPI_ADDR), .oSPI_WDATA(oSPI_WDATA),
      .iSPI_ACK(ack), .iSPI_RDATA(rdata),
      .oX(oX), .oY(oY), .oVALID(oVALID), .oDIR_X(oDIR_X), .oDIR_Y(oDIR_Y),
      .oSTOP(oSTOP), .oINIT_DONE(oINIT_DONE), .oERR(oERR)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk(tag, {8'h00, oSPI_REQ, oSPI_WR, oSPI_ADDR, oSPI_WDATA, oX, oY, oVALID,
                oDIR_X, oDIR_Y, oSTOP, oINIT_DONE, oERR},
               {8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 16'h0000, 16'h0000, 1'b0,
                2'b00, 2'b00, 1'b1, 1'b0, 1'b0});
   endtask

   task automatic wait_req(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (oSPI_REQ === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, " req_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic serve(input string tag, input logic wr, input logic [5:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rd, input int dly);
      wait_req(tag);
      chk({tag, " cmd"}, 64'({oSPI_WR, oSPI_ADDR, (wr ? oSPI_WDATA : 8'h00)}),
                         64'({wr, addr, (wr ? wdata : 8'h00)}));
      repeat (dly) @(negedge clk);
      chk({tag, " held"}, 64'({oSPI_REQ, oSPI_WR, oSPI_ADDR}), 64'({1'b1, wr, addr}));
      ack = 1'b1;
      rdata = rd;
      @(negedge clk);
      ack = 1'b0;
      rdata = 8'h5A;
      chk({tag, " req_drop"}, 64'(oSPI_REQ), 64'd0);
      $display("txn %s wr=%0d addr=0x%02h wdata=0x%02h rdata=0x%02h", tag, wr, addr, wdata, rd);
   endtask

   task automatic cfg_seq(input string tag);
      serve({tag, " w31"}, 1'b1, 6'h31, 8'h08, 8'h00, 2);
      serve({tag, " w2C"}, 1'b1, 6'h2C, 8'h0A, 8'h00, 2);
      serve({tag, " w2D"}, 1'b1, 6'h2D, 8'h08, 8'h00, 2);
      chk({tag, " init_done"}, 64'(oINIT_DONE), 64'd1);
   endtask

   task automatic burst(input string tag, input logic [7:0] b0, b1, b2, b3, input int d0,
                        input logic [15:0] ex, ey, input logic [1:0] edx, edy, input logic est);
      serve({tag, " r32"}, 1'b0, 6'h32, 8'h00, b0, d0);
      serve({tag, " r33"}, 1'b0, 6'h33, 8'h00, b1, 2);
      serve({tag, " r34"}, 1'b0, 6'h34, 8'h00, b2, 2);
      serve({tag, " r35"}, 1'b0, 6'h35, 8'h00, b3, 2);
      chk({tag, " valid"}, 64'(oVALID), 64'd1);
      chk({tag, " xy"}, 64'({oX, oY}), 64'({ex, ey}));
      chk({tag, " dir"}, 64'({oDIR_X, oDIR_Y, oSTOP}), 64'({edx, edy, est}));
      @(negedge clk);
      chk({tag, " valid_pulse"}, 64'(oVALID), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw;
      repeat (3) @(negedge clk);
      chk_reset("reset_state");
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_req_first_edge", 64'({oSPI_REQ, oINIT_DONE}), 64'd0);

      cfg_seq("cfg1");
      chk("cfg1 err", 64'(oERR), 64'd0);

      // 64 is exactly the threshold, so neither axis tilts.
      burst("A", 8'h40, 8'h00, 8'hC0, 8'hFF, 2, 16'h0040, 16'hFFC0, 2'b00, 2'b00, 1'b1);
      // First ack lands in the last cycle before timeout and must still succeed.
      burst("B", 8'h41, 8'h00, 8'hBF, 8'hFF, TIMEOUT - 1, 16'h0041, 16'hFFBF, 2'b01, 2'b10, 1'b0);
      chk("B late_ack err", 64'(oERR), 64'd0);
      burst("C", 8'h00, 8'h80, 8'hFF, 8'h7F, 2, 16'h8000, 16'h7FFF, 2'b10, 2'b01, 1'b0);

      wait_req("tmo");
      chk("tmo addr", 64'({oSPI_WR, oSPI_ADDR}), 64'({1'b0, 6'h32}));
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("tmo req_last_cycle", 64'(oSPI_REQ), 64'd1);
      @(negedge clk);
      chk("tmo req_drop", 64'(oSPI_REQ), 64'd0);
      chk("tmo err_init", 64'({oERR, oINIT_DONE}), 64'({1'b1, 1'b0}));
      chk("tmo xy_hold", 64'({oX, oY}), 64'({16'h8000, 16'h7FFF}));
      chk("tmo dir_hold", 64'({oDIR_X, oDIR_Y, oSTOP}), 64'({2'b10, 2'b01, 1'b0}));
      $display("txn tmo read 0x32 withheld ack for %0d cycles", TIMEOUT);

      cfg_seq("cfg2");
      chk("cfg2 err_sticky", 64'(oERR), 64'd1);

      hold = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 3 * POLL_DIV; i++) begin
         @(negedge clk);
         ack = (i == 10);
         if (oSPI_REQ === 1'b1 || oVALID === 1'b1) saw = 1'b1;
      end
      ack = 1'b0;
      chk("hold no_req", 64'(saw), 64'd0);
      $display("txn hold held across terminal count, stray ack ignored");
      hold = 1'b0;
      repeat (2) @(negedge clk);
      chk("hold release_read", 64'({oSPI_REQ, oSPI_WR, oSPI_ADDR}), 64'({1'b1, 1'b0, 6'h32}));

      rst_n = 1'b0;
      #1;
      chk_reset("reset_mid_read");
      $display("txn reset asserted mid-read");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
